program_loader: RTL and testbench

Synthesizable front end that fills the 4-bit computer's instruction and data memories from a host word stream, then releases the CPU to run. It drives the CPU's load port (`ins_address`, `ins`, `d_in`) and holds the CPU in reset while loading. It pads unused instruction slots with HLT and deasserts CPU reset only after every slot has been sampled. It sits between a host/UART-style source and `computer_4bit`.

---
 rtl/loader_pkg.sv | 17 +
 rtl/program_loader.sv | 162 ++++++++++++++++
 tb/tb_program_loader.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the program loader.
//   - state encoding for the loader FSM
//   - default load-port address width and padding opcode
package loader_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam logic [7:0]  HLT_OP_DEF = 8'h0F;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FILL  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RUN   = 3'd4
    } state_e;

endpackage

// File: rtl/program_loader.sv
// program_loader: fills the 4-bit computer's instruction/data memories from a
// host word stream, pads unused slots with HLT, then releases the CPU.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   host_valid/host_ready         word handshake (transfer when both high)
//   host_ins, host_data, host_last  instruction byte, data nibble, final-word mark
//   abort                         return to IDLE, reassert CPU reset
//   cpu_rst                       CPU reset / load mode (active-high)
//   ins_address, ins, d_in        CPU load port
//   busy                          high in LOAD, FILL, DRAIN
//   trunc                         sticky: every slot used without host_last
//   run_cycles                    saturating count of CPU run cycles
//
// state | meaning
// IDLE  | waiting for first word, CPU held in reset
// LOAD  | accepting host words, one slot per word
// FILL  | padding remaining slots with HLT, one per cycle
// DRAIN | one cycle so the CPU samples the final slot
// RUN   | CPU released, load port frozen, run_cycles counting
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter logic [7:0]  HLT_OP = HLT_OP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [7:0]        host_ins,
    input  logic [3:0]        host_data,
    input  logic              host_last,
    input  logic              abort,
    output logic              cpu_rst,
    output logic [ADDR_W-1:0] ins_address,
    output logic [7:0]        ins,
    output logic [3:0]        d_in,
    output logic              busy,
    output logic              trunc,
    output logic [7:0]        run_cycles
);

    localparam logic [ADDR_W-1:0] MAX_SLOT = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        ins_q, ins_d;
    logic [3:0]        din_q, din_d;
    logic              trunc_q, trunc_d;
    logic [7:0]        run_q, run_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              ready_q, ready_d;
    logic              accept;

    assign accept = host_valid && ready_q && !abort;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        ins_d     = ins_q;
        din_d     = din_q;
        trunc_d   = trunc_q;
        run_d     = run_q;
        // cpu_rst is registered from the current state, so it falls one
        // edge after RUN is entered; the extra cycle only re-samples the
        // already-loaded final slot.
        cpu_rst_d = (state_q != ST_RUN);

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    addr_d = ptr_q;
                    ins_d  = host_ins;
                    din_d  = host_data;
                    if (ptr_q == MAX_SLOT) begin
                        // pointer never wraps: the top slot always ends loading
                        state_d = ST_DRAIN;
                        if (!host_last) begin
                            trunc_d = 1'b1;
                        end
                    end else begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = host_last ? ST_FILL : ST_LOAD;
                    end
                end
            end
            ST_FILL: begin
                addr_d = ptr_q;
                ins_d  = HLT_OP;
                din_d  = 4'd0;
                if (ptr_q == MAX_SLOT) begin
                    state_d = ST_DRAIN;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // count only cycles in which the CPU is actually out of reset
                if (!cpu_rst_q && (run_q != 8'hFF)) begin
                    run_d = run_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d   = ST_IDLE;
            ptr_d     = '0;
            addr_d    = '0;
            ins_d     = HLT_OP;
            din_d     = 4'd0;
            trunc_d   = 1'b0;
            run_d     = 8'd0;
            cpu_rst_d = 1'b1;
        end

        ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            addr_q    <= '0;
            ins_q     <= HLT_OP;
            din_q     <= 4'd0;
            trunc_q   <= 1'b0;
            run_q     <= 8'd0;
            cpu_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            ins_q     <= ins_d;
            din_q     <= din_d;
            trunc_q   <= trunc_d;
            run_q     <= run_d;
            cpu_rst_q <= cpu_rst_d;
            ready_q   <= ready_d;
        end
    end

    assign host_ready  = ready_q;
    assign cpu_rst     = cpu_rst_q;
    assign ins_address = addr_q;
    assign ins         = ins_q;
    assign d_in        = din_q;
    assign trunc       = trunc_q;
    assign run_cycles  = run_q;
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_FILL) ||
                         (state_q == ST_DRAIN);

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: drives host programs into program_loader, models the CPU
// capturing the load port, and compares the captured memory image, trunc flag,
// release timing and run counter against a reference built from the program.
module tb_program_loader;

    localparam int         MAXS = 15;
    localparam logic [7:0] HLT  = 8'h0F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [7:0]  host_ins = 8'h00;
    logic [3:0]  host_data = 4'h0;
    logic        host_last = 1'b0;
    logic        abort = 1'b0;
    logic        cpu_rst;
    logic [3:0]  ins_address;
    logic [7:0]  ins;
    logic [3:0]  d_in;
    logic        busy;
    logic        trunc;
    logic [7:0]  run_cycles;

    program_loader dut (
        .clk         (clk),
        .rst         (rst),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_ins    (host_ins),
        .host_data   (host_data),
        .host_last   (host_last),
        .abort       (abort),
        .cpu_rst     (cpu_rst),
        .ins_address (ins_address),
        .ins         (ins),
        .d_in        (d_in),
        .busy        (busy),
        .trunc       (trunc),
        .run_cycles  (run_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0][11:0] img;
        bit                trunc;
        int                fall;
    } exp_t;

    exp_t              sb[$];
    exp_t              mon_e;
    logic [15:0][11:0] cpu_mem;
    bit                loading = 1'b0;
    int                last_fall = 0;

    logic [7:0] prog_ins[16];
    logic [3:0] prog_dat[16];
    bit         gap_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // CPU model: captures the load port on every edge while held in reset;
    // when released, the captured image is scored against the expectation.
    always @(negedge clk) begin
        if (cpu_rst === 1'b1) begin
            cpu_mem[ins_address] = {ins, d_in};
            loading = 1'b1;
        end else if (loading) begin
            loading   = 1'b0;
            last_fall = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_run: cpu released at cycle %0d with no program expected", cyc);
            end else begin
                mon_e = sb.pop_front();
                for (int i = 0; i < 16; i++)
                    chk($sformatf("slot%0d", i), 32'(cpu_mem[i]), 32'(mon_e.img[i]));
                chk("trunc", 32'(trunc), 32'(mon_e.trunc));
                chk("release_edge", cyc, mon_e.fall);
                chk("run_at_release", 32'(run_cycles), 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [7:0] wi, input logic [3:0] wd, input bit wl,
                             output int e, output bit ok);
        bit rdy;
        host_ins   = wi;
        host_data  = wd;
        host_last  = wl;
        host_valid = 1'b1;
        ok = 1'b0;
        e  = 0;
        for (int t = 0; t < 50; t++) begin
            rdy = host_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                e  = cyc;
                break;
            end
        end
        host_valid = 1'b0;
        host_last  = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: host_ready never seen (cycle %0d)", cyc);
        end
    endtask

    task automatic send_program(input int n, input bit use_last, input bit push);
        int   e;
        bit   ok;
        exp_t x;
        for (int i = 0; i < n; i++) begin
            if (gap_en) tick($urandom_range(0, 2));
            send_word(prog_ins[i], prog_dat[i], use_last && (i == n - 1), e, ok);
            if (!ok) return;
        end
        if (push) begin
            for (int s = 0; s < 16; s++)
                x.img[s] = (s < n) ? {prog_ins[s], prog_dat[s]} : {HLT, 4'h0};
            x.trunc = (n == 16) && !use_last;
            x.fall  = e + (MAXS - (n - 1)) + 2;
            sb.push_back(x);
        end
    endtask

    task automatic randomize_prog();
        for (int i = 0; i < 16; i++) begin
            prog_ins[i] = 8'($urandom_range(0, 255));
            prog_dat[i] = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic wait_release();
        for (int t = 0; t < 100 && sb.size() != 0; t++) tick(1);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL release_timeout: cpu_rst still high, %0d programs pending", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_run(input int extra);
        int exp_run;
        tick(extra);
        exp_run = cyc - last_fall;
        if (exp_run > 255) exp_run = 255;
        chk("run_cycles", 32'(run_cycles), exp_run);
        chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("run_host_ready", 32'(host_ready), 32'd0);
        chk("run_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_idle(input string tag, input logic exp_ready);
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        chk({tag, "_addr"}, 32'(ins_address), 32'd0);
        chk({tag, "_ins"}, 32'(ins), 32'(HLT));
        chk({tag, "_d_in"}, 32'(d_in), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_trunc"}, 32'(trunc), 32'd0);
        chk({tag, "_run"}, 32'(run_cycles), 32'd0);
        chk({tag, "_ready"}, 32'(host_ready), 32'(exp_ready));
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check_idle("abort", 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] six_i[6];
        logic [3:0] six_d[6];
        six_i = '{8'h16, 8'h02, 8'h77, 8'h00, 8'h04, 8'h0F};
        six_d = '{4'h0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0};

        // reset
        tick(2);
        check_idle("reset", 1'b0);
        rst = 1'b0;
        tick(1);
        chk("ready_after_reset", 32'(host_ready), 32'd1);

        // six-word program, back to back
        for (int i = 0; i < 6; i++) begin
            prog_ins[i] = six_i[i];
            prog_dat[i] = six_d[i];
        end
        send_program(6, 1'b1, 1'b1);
        wait_release();
        check_run(5);
        chk("frozen_addr", 32'(ins_address), 32'd15);
        chk("frozen_ins", 32'(ins), 32'(HLT));
        do_abort();

        // full program without last
        randomize_prog();
        send_program(16, 1'b0, 1'b1);
        wait_release();
        check_run(3);
        chk("trunc_sticky", 32'(trunc), 32'd1);
        do_abort();

        // gapped valid, last at slot 0
        gap_en = 1'b1;
        randomize_prog();
        tick(2);
        send_program(1, 1'b1, 1'b1);
        wait_release();
        check_run(2);
        do_abort();
        gap_en = 1'b0;

        // abort together with a valid handshake during LOAD
        randomize_prog();
        send_program(3, 1'b0, 1'b0);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_ready", 32'(host_ready), 32'd1);
        host_ins   = 8'hAA;
        host_data  = 4'h9;
        host_valid = 1'b1;
        abort      = 1'b1;
        tick(1);
        host_valid = 1'b0;
        abort      = 1'b0;
        check_idle("abort_load", 1'b1);

        // long run saturates
        randomize_prog();
        send_program(4, 1'b1, 1'b1);
        wait_release();
        check_run(300);
        chk("run_saturated", 32'(run_cycles), 32'd255);
        do_abort();

        // randomized programs
        for (int r = 0; r < 8; r++) begin
            int  n;
            bit  ul;
            n      = $urandom_range(1, 16);
            ul     = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            gap_en = 1'($urandom_range(0, 1));
            randomize_prog();
            send_program(n, ul, 1'b1);
            wait_release();
            check_run($urandom_range(0, 20));
            do_abort();
        end
        gap_en = 1'b0;

        // reset pulse mid-FILL
        randomize_prog();
        send_program(3, 1'b1, 1'b0);
        tick(2);
        chk("fill_busy", 32'(busy), 32'd1);
        chk("fill_ready", 32'(host_ready), 32'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_idle("rst_fill", 1'b0);
        tick(1);
        chk("rst_fill_ready_next", 32'(host_ready), 32'd1);
        tick(20);
        chk("rst_fill_still_idle", 32'(cpu_rst), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
